bullet_pool_ctrl: RTL
=====================

# bullet_pool_ctrl

Owns a fixed pool of bullet slots for the game layer. It arbitrates fire requests from two shooters (player A fires up, player B fires down) and allocates free slots. Once per frame it advances every live bullet and retires any that leave the screen. Its per-slot position and valid outputs feed one bullet_draw instance per slot. It runs in the pixel clock domain.

## Interface
- NUM_SLOTS, 4: number of bullet slots (2..16).
- BULLET_SPEED, 4: pixels moved per frame tick.
- SCREEN_HEIGHT, 900: visible lines; y range is 0..SCREEN_HEIGHT-1.
- COOLDOWN_FRAMES, 8: frame ticks a shooter is blocked after an accepted shot; 0 disables cooldown.

- pixclk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per frame (start of vblank).
- fire_req_a / fire_req_b  in  1 each  level request; held high until the matching ack.
- src_x_a / src_x_b  in  11 each  spawn x, sampled on the accept cycle.
- src_y_a / src_y_b  in  10 each  spawn y, sampled on the accept cycle.
- fire_ack_a / fire_ack_b  out  1 each  one-cycle pulse: shot accepted and slot allocated.
- bullet_valid  out  NUM_SLOTS  slot i is live.
- bullet_pos_x  out  11*NUM_SLOTS  slot i occupies bits [11i+10:11i].
- bullet_pos_y  out  10*NUM_SLOTS  slot i occupies bits [10i+9:10i].
- busy  out  1  high while the UPDATE pass runs.

## Operation
- Per-slot state: valid, x, y, and dir (0 = up, from A; 1 = down, from B).
- FSM has two states, IDLE and UPDATE.
- IDLE, priority order:
  - A tick arriving this cycle, or an already-pending tick, moves the FSM to UPDATE with idx = 0 and clears pending. No spawn happens that cycle.
  - Otherwise, at most one spawn per cycle.
- Spawn eligibility: a shooter is eligible when its req is high, its cooldown counter is 0, and at least one slot is free.
- Spawn arbitration: if both shooters are eligible, the round-robin pointer picks the winner. The pointer flips to the loser after each grant and resets to A.
- Spawn allocation:
  - The winner gets the lowest-index free slot: valid ← 1, x/y ← src, dir ← shooter.
  - Its ack pulses and its cooldown loads COOLDOWN_FRAMES.
  - If the pool is full, no ack is issued and the request stays pending.
- UPDATE processes one slot per cycle, idx 0..NUM_SLOTS-1, then returns to IDLE. busy is high for exactly NUM_SLOTS cycles.
  - dir up: if y < BULLET_SPEED, clear valid; else y ← y − BULLET_SPEED.
  - dir down: if y + BULLET_SPEED ≥ SCREEN_HEIGHT, clear valid; else y ← y + BULLET_SPEED. Compute the sum 11 bits wide, so there is no wrap.
  - Invalid slots are untouched. x never changes.
- Cooldown counters:
  - Each nonzero counter decrements by 1 on every frame_tick, in any state, saturating at 0.
  - If a load and a decrement coincide, the load wins.
- Tick during UPDATE: sets pending, at most one level. Further ticks while pending is set are dropped.
- Retired slots keep their stale x/y. Consumers must qualify positions with bullet_valid.

## Timing
- Reset values:
  - All valid = 0; all x, y, dir = 0.
  - fire_ack_a/b = 0, busy = 0.
  - FSM = IDLE, pending = 0, rr pointer = A, cooldowns = 0.
- Spawn latency:
  - req is sampled high in IDLE at edge n.
  - ack, valid, and position are all visible after edge n, together.
  - The requester drops req on the cycle after it sees ack. A req still high at the next edge is treated as a new shot, subject to cooldown.
- Update latency: tick at edge n → busy high from edge n+1 through edge n+NUM_SLOTS. Slot i's result is visible after edge n+1+i.
- Tick and req in the same IDLE cycle: the update goes first. The spawn is serviced on the first IDLE cycle after the pass.
- Reset mid-UPDATE: the pool clears immediately; no partial pass resumes.

## Test plan
- Reset, then fire_req_a with src (100, 500) → fire_ack_a pulses one cycle later. Slot 0 valid, x = 100, y = 500. After 3 ticks, y = 488.
- Both requests high together from reset → A acked into slot 0, then B into slot 1 on the next cycle. rr pointer now A; B moves +4 per tick.
- Fill 4 slots; fifth request held → no ack. After a B bullet at y = 897 retires (897 + 4 ≥ 900), ack follows on the first IDLE cycle after the pass, into the freed slot index.
- A bullet at y = 3 moving up → retired on next tick. A bullet at y = 4 → y = 0, retired on the following tick.
- Cooldown: after A is accepted, req_a is held → no ack for the next 8 ticks, ack after the 8th tick's pass. With COOLDOWN_FRAMES = 0, back-to-back acks occur.
- Tick during UPDATE → busy stays high for 2×NUM_SLOTS consecutive cycles. Asserting rst mid-pass → all valid = 0 and busy = 0 on the next edge.

Source files
------------

// File: rtl/bullet_pool_if.sv
// bullet_pool_if
//   Bundles the game-layer side of bullet_pool_ctrl: frame tick, the two
//   shooter request/ack pairs with their spawn coordinates, the per-slot
//   pool outputs and a small debug view of the controller state.
//
//   Handshake: fire_req_x is a level request held high by the shooter until
//   it sees fire_ack_x. fire_ack_x is a one-cycle pulse that means the shot
//   was accepted and a slot was written with the spawn coordinates. A request
//   still high on the edge after the ack counts as a new shot.
//
//   master : game logic / bench (drives requests and frame_tick)
//   slave  : bullet_pool_ctrl
interface bullet_pool_if #(
  parameter int NUM_SLOTS = 4
) ();
  logic                     frame_tick;
  logic                     fire_req_a;
  logic                     fire_req_b;
  logic [10:0]              src_x_a;
  logic [10:0]              src_x_b;
  logic [9:0]               src_y_a;
  logic [9:0]               src_y_b;
  logic                     fire_ack_a;
  logic                     fire_ack_b;
  logic [NUM_SLOTS-1:0]     bullet_valid;
  logic [11*NUM_SLOTS-1:0]  bullet_pos_x;
  logic [10*NUM_SLOTS-1:0]  bullet_pos_y;
  logic                     busy;
  logic [0:0]               dbg_state;
  logic                     dbg_pending;
  logic                     dbg_rr;

  modport master (
    output frame_tick, fire_req_a, fire_req_b,
    output src_x_a, src_x_b, src_y_a, src_y_b,
    input  fire_ack_a, fire_ack_b,
    input  bullet_valid, bullet_pos_x, bullet_pos_y, busy,
    input  dbg_state, dbg_pending, dbg_rr
  );

  modport slave (
    input  frame_tick, fire_req_a, fire_req_b,
    input  src_x_a, src_x_b, src_y_a, src_y_b,
    output fire_ack_a, fire_ack_b,
    output bullet_valid, bullet_pos_x, bullet_pos_y, busy,
    output dbg_state, dbg_pending, dbg_rr
  );
endinterface

// File: rtl/bullet_pool_ctrl.sv
// bullet_pool_ctrl
//   Owns a fixed pool of bullet slots. Arbitrates fire requests from shooter
//   A (fires up) and shooter B (fires down), allocates the lowest free slot,
//   and once per frame walks every slot (one per cycle) to advance live
//   bullets and retire those leaving the screen.
//
//   Ports:
//     pixclk  - pixel clock, all logic on its rising edge
//     rst     - synchronous active-high reset
//     bus     - bullet_pool_if.slave: frame_tick, fire_req/ack/src per
//               shooter, bullet_valid/pos_x/pos_y per slot, busy, debug
//
//   Retired slots keep their last x/y; consumers qualify with bullet_valid.
module bullet_pool_ctrl #(
  parameter int NUM_SLOTS       = 4,
  parameter int BULLET_SPEED    = 4,
  parameter int SCREEN_HEIGHT   = 900,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic          pixclk,
  input  logic          rst,
  bullet_pool_if.slave  bus
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CD_W  = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_UPDATE = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  logic [0:0]           state;
  logic [IDX_W-1:0]     idx;
  logic                 pending;
  logic                 rr;         // 0: A wins a tie, 1: B wins a tie
  logic [CD_W-1:0]      cd_a;
  logic [CD_W-1:0]      cd_b;
  logic                 ack_a_q;
  logic                 ack_b_q;

  logic [NUM_SLOTS-1:0] slot_valid;
  logic [NUM_SLOTS-1:0] slot_dir;   // 0 = up (A), 1 = down (B)
  logic [10:0]          slot_x [NUM_SLOTS];
  logic [9:0]           slot_y [NUM_SLOTS];

  // Lowest-index free slot
  logic                 any_free;
  logic [IDX_W-1:0]     free_idx;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // A tick (new or pending) in IDLE pre-empts any spawn that cycle.
  logic tick_go;
  logic spawn_ok;
  logic elig_a;
  logic elig_b;
  logic grant_a;
  logic grant_b;

  always_comb begin
    tick_go  = (state == ST_IDLE) && (bus.frame_tick || pending);
    spawn_ok = (state == ST_IDLE) && !bus.frame_tick && !pending;
    elig_a   = bus.fire_req_a && (cd_a == '0) && any_free;
    elig_b   = bus.fire_req_b && (cd_b == '0) && any_free;
    grant_a  = spawn_ok && elig_a && (!elig_b || !rr);
    grant_b  = spawn_ok && elig_b && (!elig_a ||  rr);
  end

  // Per-slot motion for the slot under idx. The down sum is 11 bits so a
  // bullet near the bottom edge cannot wrap back to a small y.
  logic [10:0] y_ext;
  logic [10:0] y_sum;
  logic [9:0]  y_diff;
  logic        retire;
  logic [9:0]  next_y;

  always_comb begin
    y_ext  = {1'b0, slot_y[idx]};
    y_sum  = y_ext + 11'(BULLET_SPEED);
    y_diff = slot_y[idx] - 10'(BULLET_SPEED);
    if (slot_dir[idx]) begin
      retire = (y_sum >= 11'(SCREEN_HEIGHT));
      next_y = y_sum[9:0];
    end else begin
      retire = (y_ext < 11'(BULLET_SPEED));
      next_y = y_diff;
    end
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      pending    <= 1'b0;
      rr         <= 1'b0;
      cd_a       <= '0;
      cd_b       <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
      slot_valid <= '0;
      slot_dir   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_x[i] <= '0;
        slot_y[i] <= '0;
      end
    end else begin
      ack_a_q <= grant_a;
      ack_b_q <= grant_b;

      // Cooldown: a load on grant wins over the per-tick decrement.
      if (grant_a) begin
        cd_a <= CD_W'(COOLDOWN_FRAMES);
      end else if (bus.frame_tick && (cd_a != '0)) begin
        cd_a <= cd_a - 1'b1;
      end
      if (grant_b) begin
        cd_b <= CD_W'(COOLDOWN_FRAMES);
      end else if (bus.frame_tick && (cd_b != '0)) begin
        cd_b <= cd_b - 1'b1;
      end

      if (grant_a || grant_b) begin
        slot_valid[free_idx] <= 1'b1;
        slot_dir[free_idx]   <= grant_b;
        slot_x[free_idx]     <= grant_a ? bus.src_x_a : bus.src_x_b;
        slot_y[free_idx]     <= grant_a ? bus.src_y_a : bus.src_y_b;
        rr                   <= grant_a;   // pointer moves to the loser
      end

      case (state)
        ST_IDLE: begin
          if (tick_go) begin
            state   <= ST_UPDATE;
            idx     <= '0;
            pending <= 1'b0;
          end
        end
        ST_UPDATE: begin
          if (slot_valid[idx]) begin
            if (retire) begin
              slot_valid[idx] <= 1'b0;
            end else begin
              slot_y[idx] <= next_y;
            end
          end
          if (idx == LAST_IDX) begin
            // A queued tick restarts the pass directly so busy stays
            // continuous across back-to-back passes.
            if (pending || bus.frame_tick) begin
              idx     <= '0;
              pending <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            idx <= idx + 1'b1;
            if (bus.frame_tick) begin
              pending <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  logic [11*NUM_SLOTS-1:0] pos_x_flat;
  logic [10*NUM_SLOTS-1:0] pos_y_flat;

  always_comb begin
    pos_x_flat = '0;
    pos_y_flat = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pos_x_flat[11*i +: 11] = slot_x[i];
      pos_y_flat[10*i +: 10] = slot_y[i];
    end
  end

  assign bus.fire_ack_a   = ack_a_q;
  assign bus.fire_ack_b   = ack_b_q;
  assign bus.bullet_valid = slot_valid;
  assign bus.bullet_pos_x = pos_x_flat;
  assign bus.bullet_pos_y = pos_y_flat;
  assign bus.busy         = (state == ST_UPDATE);
  assign bus.dbg_state    = state;
  assign bus.dbg_pending  = pending;
  assign bus.dbg_rr       = rr;

endmodule
